// File: rtl/leaf_stream_tx_if.sv
// Stream bundle between the leaf transmitter and its neighbours.
// Carries the user-side valid/ack stream and the BFT-side packet bus.
// The transmitter connects through the slave modport.
// The driving environment (user kernel plus BFT) connects through the master modport.
interface leaf_stream_tx_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din_user2tx;
    logic                    vld_user2tx;
    logic                    ack_tx2user;
    logic [PACKET_BITS-1:0]  dout_tx2bft;
    logic                    rdy_bft2tx;
    logic [PACKET_BITS-1:0]  din_bft2tx;

    modport master (
        output din_user2tx,
        output vld_user2tx,
        input  ack_tx2user,
        input  dout_tx2bft,
        output rdy_bft2tx,
        output din_bft2tx
    );

    modport slave (
        input  din_user2tx,
        input  vld_user2tx,
        output ack_tx2user,
        output dout_tx2bft,
        input  rdy_bft2tx,
        input  din_bft2tx
    );
endinterface

// File: rtl/leaf_stream_tx.sv
// leaf_stream_tx: transmit end of the leaf packet protocol.
// Packs a user valid/ack stream into BFT packets that target a remote leaf input port.
// Flow control is credit based. Credits track free receiver BRAM slots and are refilled by freespace packets.
// Optional feature: define LEAF_TX_STALL_CNT_EN to add a saturating stall counter output (stall_cnt).
module leaf_stream_tx #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 4,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    leaf_stream_tx_if.slave          bus,
    output logic [NUM_ADDR_BITS:0]   credit_cnt,
    output logic                     credit_ovf
`ifdef LEAF_TX_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    localparam int TYPE_BIT = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam logic [NUM_ADDR_BITS+1:0] MAX_CREDIT = (NUM_ADDR_BITS+2)'(1) << NUM_ADDR_BITS;

    logic [0:0]               state_q,  state_d;
    logic [PACKET_BITS-1:0]   dout_q,   dout_d;
    logic [NUM_ADDR_BITS-1:0] addr_q,   addr_d;
    logic [NUM_ADDR_BITS:0]   credit_q, credit_d;
    logic                     ovf_q,    ovf_d;

    logic                     ack;
    logic                     xfer;
    logic                     upd;
    logic [NUM_ADDR_BITS+1:0] upd_amt;
    logic [NUM_ADDR_BITS+1:0] credit_sum;

    // Only the valid bit, the type bit and the credit field of incoming packets matter.
    logic unused_bft_bits;
    assign unused_bft_bits = ^{bus.din_bft2tx[PACKET_BITS-2:TYPE_BIT+1],
                               bus.din_bft2tx[TYPE_BIT-1:NUM_ADDR_BITS+1]};

    // Clamp a credit sum to the receiver capacity.
    function automatic logic [NUM_ADDR_BITS:0] sat_credit(input logic [NUM_ADDR_BITS+1:0] sum);
        if (sum > MAX_CREDIT) begin
            return MAX_CREDIT[NUM_ADDR_BITS:0];
        end
        return sum[NUM_ADDR_BITS:0];
    endfunction

    // Accept user data when credit remains and the output register is free or being drained this cycle.
    always_comb begin
        ack  = !reset && (credit_q != '0) && ((state_q == S_EMPTY) || bus.rdy_bft2tx);
        xfer = bus.vld_user2tx && ack;
    end

    // Next-state logic for the output register, the address pointer and the credit counter.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        addr_d  = addr_q;

        if (xfer) begin
            dout_d  = {1'b1, cfg_dest_leaf, cfg_dest_port, 1'b0, addr_q, bus.din_user2tx};
            state_d = S_HOLD;
            addr_d  = addr_q + 1'b1;
        end else if ((state_q == S_HOLD) && bus.rdy_bft2tx) begin
            dout_d  = '0;
            state_d = S_EMPTY;
        end

        upd        = bus.din_bft2tx[PACKET_BITS-1] && bus.din_bft2tx[TYPE_BIT];
        upd_amt    = upd ? {1'b0, bus.din_bft2tx[NUM_ADDR_BITS:0]} : '0;
        // xfer implies credit_q != 0, so the subtraction cannot underflow.
        credit_sum = {1'b0, credit_q} - {{(NUM_ADDR_BITS+1){1'b0}}, xfer} + upd_amt;
        credit_d   = sat_credit(credit_sum);
        ovf_d      = ovf_q || (credit_sum > MAX_CREDIT);
    end

    // Register update. Reset drops any held packet and restores full credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            dout_q   <= '0;
            addr_q   <= '0;
            credit_q <= MAX_CREDIT[NUM_ADDR_BITS:0];
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ack_tx2user = ack;
    assign bus.dout_tx2bft = dout_q;
    assign credit_cnt      = credit_q;
    assign credit_ovf      = ovf_q;

`ifdef LEAF_TX_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count cycles where the user offers data but is refused, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (bus.vld_user2tx && !ack && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_leaf_stream_tx.sv
// Directed testbench for leaf_stream_tx.
// Runs a linear sequence of directed steps.
// Each expected value is checked with an immediate assertion.
// The stall counter checks are compiled in only when LEAF_TX_STALL_CNT_EN is defined.
module tb_leaf_stream_tx;

    logic       clk;
    logic       reset;
    logic [3:0] cfg_dest_leaf;
    logic [3:0] cfg_dest_port;
    logic [7:0] credit_cnt;
    logic       credit_ovf;
`ifdef LEAF_TX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp;
    int n_err;

    leaf_stream_tx_if bus ();

    leaf_stream_tx dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_dest_leaf (cfg_dest_leaf),
        .cfg_dest_port (cfg_dest_port),
        .bus           (bus.slave),
        .credit_cnt    (credit_cnt),
        .credit_ovf    (credit_ovf)
`ifdef LEAF_TX_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] pkt(input logic [3:0] l, input logic [3:0] p,
                                        input logic [6:0] a, input logic [31:0] d);
        return {1'b1, l, p, 1'b0, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        cfg_dest_leaf = 4'd3;
        cfg_dest_port = 4'd2;
        bus.din_user2tx = '0;
        bus.vld_user2tx = 1'b0;
        bus.rdy_bft2tx  = 1'b0;
        bus.din_bft2tx  = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack", {63'd0, bus.ack_tx2user}, 64'd0);
        check("rst_dout", {15'd0, bus.dout_tx2bft}, 64'd0);
        check("rst_credit", {56'd0, credit_cnt}, 64'd128);
        check("rst_ovf", {63'd0, credit_ovf}, 64'd0);
        reset = 1'b0;
        #1;
        check("idle_ack", {63'd0, bus.ack_tx2user}, 64'd1);

        // First packet: leaf 3, port 2, addr 0
        bus.vld_user2tx = 1'b1;
        bus.din_user2tx = 32'hA5A5_0001;
        bus.rdy_bft2tx  = 1'b1;
        tick();
        check("first_pkt", {15'd0, bus.dout_tx2bft}, {15'd0, 49'h1_3200_A5A5_0001});
        check("first_credit", {56'd0, credit_cnt}, 64'd127);
        bus.vld_user2tx = 1'b0;
        tick();
        check("drain_empty", {15'd0, bus.dout_tx2bft}, 64'd0);

        // 130 back-to-back words from fresh reset: exactly 128 accepted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.vld_user2tx = 1'b1;
        for (int i = 0; i < 130; i++) begin
            bus.din_user2tx = 32'h1000_0000 + i;
            #1;
            check($sformatf("b2b_ack_%0d", i), {63'd0, bus.ack_tx2user}, (i < 128) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("b2b_dout_%0d", i), {15'd0, bus.dout_tx2bft},
                  (i < 128) ? {15'd0, pkt(4'd3, 4'd2, 7'(i), 32'h1000_0000 + i)} : 64'd0);
        end
        check("b2b_credit0", {56'd0, credit_cnt}, 64'd0);

        // Freespace update of 16 resumes traffic; addresses wrap to 0
        bus.din_bft2tx = {1'b1, 4'd0, 4'd0, 1'b1, 7'd0, 32'd16};
        #1;
        check("upd_ack_low", {63'd0, bus.ack_tx2user}, 64'd0);
        tick();
        bus.din_bft2tx = '0;
        check("upd_credit16", {56'd0, credit_cnt}, 64'd16);
        for (int j = 0; j < 17; j++) begin
            bus.din_user2tx = 32'h2000_0000 + j;
            #1;
            check($sformatf("wrap_ack_%0d", j), {63'd0, bus.ack_tx2user}, (j < 16) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("wrap_dout_%0d", j), {15'd0, bus.dout_tx2bft},
                  (j < 16) ? {15'd0, pkt(4'd3, 4'd2, 7'(j), 32'h2000_0000 + j)} : 64'd0);
        end
        check("wrap_credit0", {56'd0, credit_cnt}, 64'd0);

        // Backpressure: held packet is stable, later cfg changes do not touch it
        bus.vld_user2tx = 1'b0;
        bus.din_bft2tx  = {1'b1, 4'd0, 4'd0, 1'b1, 7'd0, 32'd8};
        tick();
        bus.din_bft2tx  = '0;
        check("bp_credit8", {56'd0, credit_cnt}, 64'd8);
        bus.vld_user2tx = 1'b1;
        bus.din_user2tx = 32'hD1D1_D1D1;
        tick();
        check("bp_pkt1", {15'd0, bus.dout_tx2bft}, {15'd0, pkt(4'd3, 4'd2, 7'd16, 32'hD1D1_D1D1)});
        bus.rdy_bft2tx  = 1'b0;
        bus.din_user2tx = 32'hD2D2_D2D2;
        cfg_dest_leaf   = 4'd5;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_ack_%0d", k), {63'd0, bus.ack_tx2user}, 64'd0);
            tick();
            check($sformatf("bp_hold_%0d", k), {15'd0, bus.dout_tx2bft},
                  {15'd0, pkt(4'd3, 4'd2, 7'd16, 32'hD1D1_D1D1)});
        end
        bus.rdy_bft2tx = 1'b1;
        #1;
        check("bp_release_ack", {63'd0, bus.ack_tx2user}, 64'd1);
        tick();
        check("bp_pkt2", {15'd0, bus.dout_tx2bft}, {15'd0, pkt(4'd5, 4'd2, 7'd17, 32'hD2D2_D2D2)});
        check("bp_credit6", {56'd0, credit_cnt}, 64'd6);
        bus.vld_user2tx = 1'b0;
        tick();
        check("bp_drained", {15'd0, bus.dout_tx2bft}, 64'd0);

        // Overflow: credit 127, data-type packet ignored, then transfer + update of 4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.vld_user2tx = 1'b1;
        bus.din_user2tx = 32'h3333_0000;
        tick();
        check("ovf_credit127", {56'd0, credit_cnt}, 64'd127);
        bus.vld_user2tx = 1'b0;
        bus.din_bft2tx  = {1'b1, 4'd0, 4'd0, 1'b0, 7'd0, 32'd4};
        tick();
        check("type0_ignored", {56'd0, credit_cnt}, 64'd127);
        bus.vld_user2tx = 1'b1;
        bus.din_user2tx = 32'h3333_0001;
        bus.din_bft2tx  = {1'b1, 4'd0, 4'd0, 1'b1, 7'd0, 32'd4};
        tick();
        check("ovf_credit_sat", {56'd0, credit_cnt}, 64'd128);
        check("ovf_flag", {63'd0, credit_ovf}, 64'd1);
        bus.vld_user2tx = 1'b0;
        bus.din_bft2tx  = '0;
        tick();
        check("ovf_sticky", {63'd0, credit_ovf}, 64'd1);
        bus.vld_user2tx = 1'b1;
        bus.rdy_bft2tx  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst2_ovf", {63'd0, credit_ovf}, 64'd0);
        check("rst2_dout", {15'd0, bus.dout_tx2bft}, 64'd0);
        check("rst2_credit", {56'd0, credit_cnt}, 64'd128);
        reset = 1'b0;
        bus.vld_user2tx = 1'b0;
        tick();
        check("rst2_no_partial", {15'd0, bus.dout_tx2bft}, 64'd0);

`ifdef LEAF_TX_STALL_CNT_EN
        // Stall counter: one accepted word, then ten refused cycles
        check("stall_rst", {48'd0, stall_cnt}, 64'd0);
        bus.vld_user2tx = 1'b1;
        bus.rdy_bft2tx  = 1'b0;
        tick();
        for (int s = 0; s < 10; s++) tick();
        check("stall_cnt10", {48'd0, stall_cnt}, 64'd10);
        bus.vld_user2tx = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
